gcd_stream: RTL and testbench

Parametrised, handshaked greatest-common-divisor engine. It is the next generation of the fixed 2-bit, load-strobe GCD block used as the emulation-engine example design. Operands of any width are accepted over a valid/ready input channel. The result is computed with the binary (Stein) algorithm in a bounded number of cycles, then returned on a valid/ready output channel together with the iteration count. It is intended as a larger, backpressure-aware example design for emulation and compiler regression.

---
 rtl/gcd_stream.sv | 160 ++++++++++++++++
 tb/tb_gcd_stream.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_stream.sv
// gcd_stream: handshaked binary (Stein) GCD engine.
// A single step module holds the per-cycle reduction rule.
// The top holds the IDLE/WORK/DONE control and the operand/result registers.

// One Stein reduction step. It is purely combinational.
// done flags a==b, and result is then the gcd with the common factor 2^k restored.
module gcd_step #(
    parameter int WIDTH = 16,
    parameter int KW    = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] a_nxt,
    output logic [WIDTH-1:0] b_nxt,
    output logic [KW-1:0]    k_nxt,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    logic [WIDTH-1:0] diff_ab;
    logic [WIDTH-1:0] diff_ba;

    // Only the branch selected by the priority chain below ever uses one of these.
    // That branch always has the larger operand as the minuend, so it never wraps.
    assign diff_ab = a - b;
    assign diff_ba = b - a;

    // Priority-ordered reduction: equal, both even, one even, then odd-odd subtract.
    always_comb begin
        a_nxt  = a;
        b_nxt  = b;
        k_nxt  = k;
        done   = 1'b0;
        result = a << k;
        if (a == b) begin
            done = 1'b1;
        end else if (!a[0] && !b[0]) begin
            a_nxt = a >> 1;
            b_nxt = b >> 1;
            k_nxt = k + KW'(1);
        end else if (!a[0]) begin
            a_nxt = a >> 1;
        end else if (!b[0]) begin
            b_nxt = b >> 1;
        end else if (a > b) begin
            a_nxt = diff_ab >> 1;
        end else begin
            b_nxt = diff_ba >> 1;
        end
    end
endmodule

module gcd_stream #(
    parameter  int WIDTH = 16,
    localparam int CW    = $clog2(2*WIDTH+2)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_a,
    input  logic [WIDTH-1:0] io_in_b,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_gcd,
    output logic [CW-1:0]    io_out_cycles
);
    localparam int KW = $clog2(WIDTH+1);

    typedef enum logic [1:0] {IDLE, WORK, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [KW-1:0]    k_q, k_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;

    logic [WIDTH-1:0] step_a;
    logic [WIDTH-1:0] step_b;
    logic [KW-1:0]    step_k;
    logic             step_done;
    logic [WIDTH-1:0] step_res;

    gcd_step #(.WIDTH(WIDTH), .KW(KW)) u_step (
        .a      (a_q),
        .b      (b_q),
        .k      (k_q),
        .a_nxt  (step_a),
        .b_nxt  (step_b),
        .k_nxt  (step_k),
        .done   (step_done),
        .result (step_res)
    );

    assign io_in_ready   = (state == IDLE);
    assign io_out_valid  = (state == DONE);
    assign io_out_gcd    = res_q;
    assign io_out_cycles = cnt_q;

    // State and datapath registers. Reset discards any operation in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            k_q   <= '0;
            cnt_q <= '0;
            res_q <= '0;
        end else begin
            state <= state_nxt;
            a_q   <= a_d;
            b_q   <= b_d;
            k_q   <= k_d;
            cnt_q <= cnt_d;
            res_q <= res_d;
        end
    end

    // Next-state and datapath update. Registers hold unless the current state advances them.
    always_comb begin
        state_nxt = state;
        a_d       = a_q;
        b_d       = b_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        case (state)
            IDLE: begin
                if (io_in_valid) begin
                    a_d   = io_in_a;
                    b_d   = io_in_b;
                    k_d   = '0;
                    cnt_d = '0;
                    // A zero operand gives the other operand directly, with no WORK cycles.
                    if (io_in_a == '0 || io_in_b == '0) begin
                        res_d     = io_in_a | io_in_b;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = WORK;
                    end
                end
            end
            WORK: begin
                cnt_d = cnt_q + CW'(1);
                a_d   = step_a;
                b_d   = step_b;
                k_d   = step_k;
                if (step_done) begin
                    res_d     = step_res;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (io_out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_gcd_stream.sv
// Bench for gcd_stream.
// Directed vectors and corner sequences run on an 8-bit instance.
// A throttled random regression runs on a 16-bit instance against a Euclid reference.
module tb_gcd_stream;
    logic clock;
    logic reset;

    logic       in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0] in_a8, in_b8, gcd8;
    logic [4:0] cycles8;

    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] in_a16, in_b16, gcd16;
    logic [5:0]  cycles16;

    int n_checks = 0;
    int n_fail   = 0;

    gcd_stream #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset),
        .io_in_valid(in_valid8), .io_in_ready(in_ready8),
        .io_in_a(in_a8), .io_in_b(in_b8),
        .io_out_valid(out_valid8), .io_out_ready(out_ready8),
        .io_out_gcd(gcd8), .io_out_cycles(cycles8)
    );

    gcd_stream #(.WIDTH(16)) dut16 (
        .clock(clock), .reset(reset),
        .io_in_valid(in_valid16), .io_in_ready(in_ready16),
        .io_in_a(in_a16), .io_in_b(in_b16),
        .io_out_valid(out_valid16), .io_out_ready(out_ready16),
        .io_out_gcd(gcd16), .io_out_cycles(cycles16)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] gcd;
        int         cycles;
        string      name;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_gcd(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Wait for idle, offer one pair with out_ready=1, and check latency, result and the one-cycle valid pulse.
    task automatic run_vec(input logic [7:0] a, input logic [7:0] b, input logic [7:0] g,
                           input int cyc, input string nm);
        int t;
        t = 0;
        while (!in_ready8 && t < 60) begin @(negedge clock); t++; end
        chk({nm, " idle"}, {31'd0, in_ready8}, 32'd1);
        out_ready8 = 1'b1;
        in_valid8  = 1'b1;
        in_a8      = a;
        in_b8      = b;
        @(negedge clock);
        in_valid8 = 1'b0;
        in_a8     = 8'hA5;
        in_b8     = 8'h5A;
        t = 1;
        while (!out_valid8 && t < 60) begin @(negedge clock); t++; end
        chk({nm, " latency"}, t, cyc + 1);
        chk({nm, " gcd"}, {24'd0, gcd8}, {24'd0, g});
        chk({nm, " cycles"}, {27'd0, cycles8}, cyc);
        @(negedge clock);
        chk({nm, " valid pulse"}, {31'd0, out_valid8}, 32'd0);
        chk({nm, " ready back"}, {31'd0, in_ready8}, 32'd1);
    endtask

    initial begin
        int t;
        int seen;

        vecs[0] = '{8'd12,  8'd18,  8'd6,   4, "12_18"};
        vecs[1] = '{8'd1,   8'd255, 8'd1,   8, "1_255"};
        vecs[2] = '{8'd128, 8'd64,  8'd64,  8, "128_64"};
        vecs[3] = '{8'd48,  8'd48,  8'd48,  1, "48_48"};
        vecs[4] = '{8'd0,   8'd7,   8'd7,   0, "0_7"};
        vecs[5] = '{8'd0,   8'd0,   8'd0,   0, "0_0"};
        vecs[6] = '{8'd7,   8'd0,   8'd7,   0, "7_0"};
        vecs[7] = '{8'd9,   8'd6,   8'd3,   3, "9_6"};
        vecs[8] = '{8'd255, 8'd255, 8'd255, 1, "255_255"};
        vecs[9] = '{8'd5,   8'd10,  8'd5,   2, "5_10"};

        in_valid8 = 1'b1; in_a8 = 8'd5; in_b8 = 8'd10; out_ready8 = 1'b1;
        in_valid16 = 1'b0; in_a16 = '0; in_b16 = '0; out_ready16 = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;

        // Reset held with a valid pair offered: the engine stays idle with zero outputs.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("rst in_ready", {31'd0, in_ready8}, 32'd1);
            chk("rst out_valid", {31'd0, out_valid8}, 32'd0);
            chk("rst gcd", {24'd0, gcd8}, 32'd0);
            chk("rst cycles", {27'd0, cycles8}, 32'd0);
        end
        reset = 1'b1;
        @(negedge clock);
        chk("first accept", {31'd0, in_ready8}, 32'd0);
        in_valid8 = 1'b0;
        t = 1;
        while (!out_valid8 && t < 60) begin @(negedge clock); t++; end
        chk("first latency", t, 32'd3);
        chk("first gcd", {24'd0, gcd8}, 32'd5);
        chk("first cycles", {27'd0, cycles8}, 32'd2);
        @(negedge clock);

        for (int i = 0; i < 10; i++)
            run_vec(vecs[i].a, vecs[i].b, vecs[i].gcd, vecs[i].cycles, vecs[i].name);

        // Backpressure: the result is held, and the second pair waits for the handshake.
        out_ready8 = 1'b0; in_valid8 = 1'b1; in_a8 = 8'd12; in_b8 = 8'd18;
        @(negedge clock);
        in_a8 = 8'd9; in_b8 = 8'd6;
        t = 1;
        while (!out_valid8 && t < 60) begin @(negedge clock); t++; end
        chk("bp latency", t, 32'd5);
        for (int i = 0; i < 10; i++) begin
            chk("bp valid held", {31'd0, out_valid8}, 32'd1);
            chk("bp gcd held", {24'd0, gcd8}, 32'd6);
            chk("bp cycles held", {27'd0, cycles8}, 32'd4);
            chk("bp in_ready low", {31'd0, in_ready8}, 32'd0);
            @(negedge clock);
        end
        out_ready8 = 1'b1;
        @(negedge clock);
        chk("bp released", {31'd0, out_valid8}, 32'd0);
        chk("bp 2nd not yet", {31'd0, in_ready8}, 32'd1);
        @(negedge clock);
        chk("bp 2nd accepted", {31'd0, in_ready8}, 32'd0);
        in_valid8 = 1'b0;
        t = 1;
        while (!out_valid8 && t < 60) begin @(negedge clock); t++; end
        chk("bp 2nd latency", t, 32'd4);
        chk("bp 2nd gcd", {24'd0, gcd8}, 32'd3);
        chk("bp 2nd cycles", {27'd0, cycles8}, 32'd3);
        @(negedge clock);

        // Reset pulse in WORK cycle 3 of (1,255): the operation is lost.
        in_valid8 = 1'b1; in_a8 = 8'd1; in_b8 = 8'd255;
        @(negedge clock);
        in_valid8 = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("midrst in_ready", {31'd0, in_ready8}, 32'd1);
        chk("midrst out_valid", {31'd0, out_valid8}, 32'd0);
        chk("midrst gcd", {24'd0, gcd8}, 32'd0);
        chk("midrst cycles", {27'd0, cycles8}, 32'd0);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (out_valid8) seen++;
        end
        chk("midrst no result", seen, 32'd0);
        run_vec(8'd9, 8'd6, 8'd3, 3, "after rst 9_6");

        // Random regression on the 16-bit engine with throttled valid and ready.
        begin
            logic [15:0] exp_q[$];
            int n_recv;
            n_recv = 0;
            fork
                begin : drv
                    int w;
                    int r;
                    for (int i = 0; i < 1000; i++) begin
                        repeat ($urandom_range(0, 2)) @(negedge clock);
                        r = $urandom_range(0, 7);
                        in_a16 = 16'($urandom);
                        in_b16 = 16'($urandom);
                        if (r == 0) in_a16 = '0;
                        if (r == 1) in_b16 = '0;
                        if (r == 2) in_b16 = in_a16;
                        if (r == 3) begin
                            in_a16 = in_a16 << 4;
                            in_b16 = in_b16 << 5;
                        end
                        in_valid16 = 1'b1;
                        w = 0;
                        while (!in_ready16 && w < 300) begin @(negedge clock); w++; end
                        chk("rnd accept timeout", {31'd0, in_ready16}, 32'd1);
                        exp_q.push_back(ref_gcd(in_a16, in_b16));
                        @(negedge clock);
                        in_valid16 = 1'b0;
                    end
                end
                begin : mon
                    int cyc;
                    logic [15:0] e;
                    cyc = 0;
                    while (n_recv < 1000 && cyc < 60000) begin
                        @(negedge clock);
                        cyc++;
                        out_ready16 = ($urandom_range(0, 3) != 0);
                        if (out_valid16 && out_ready16) begin
                            if (exp_q.size() == 0) begin
                                chk("rnd unexpected result", {16'd0, gcd16}, 32'hFFFF_FFFF);
                            end else begin
                                e = exp_q.pop_front();
                                chk("rnd gcd", {16'd0, gcd16}, {16'd0, e});
                                chk("rnd cycles bound", {31'd0, (cycles16 <= 6'd33)}, 32'd1);
                            end
                            n_recv++;
                        end
                    end
                end
            join
            chk("rnd results received", n_recv, 32'd1000);
            chk("rnd none pending", exp_q.size(), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
